// File: rtl/strip_frame_gen_if.sv
// Frame handshake between the strip frame source and strip_frame_gen.
// The source drives frame_in/frame_valid; the framer answers with frame_ready.
interface strip_frame_gen_if;
   logic [103:0] frame_in;
   logic         frame_valid;
   logic         frame_ready;

   modport master (output frame_in, output frame_valid, input frame_ready);
   modport slave  (input frame_in, input frame_valid, output frame_ready);
endinterface

// File: rtl/strip_frame_gen.sv
// Strip link framer: 104-bit frame -> four {1010, 26-bit} words plus MIN_GAP idle words.
// Optional self-launching test pattern source enabled by STRIP_FRAME_GEN_TESTPAT_EN.
module strip_frame_gen #(
   parameter int unsigned MIN_GAP  = 1,
   parameter logic [3:0]  IDLE_HDR = 4'b0101
) (
   input  logic               clk160,
   input  logic               reset,
`ifdef STRIP_FRAME_GEN_TESTPAT_EN
   input  logic               test_mode,
`endif
   strip_frame_gen_if.slave   src,
   output logic [29:0]        strip_data_out,
   output logic               busy,
   output logic [15:0]        frames_sent
);

   localparam logic [3:0]  DataHdr  = 4'b1010;
   localparam logic [29:0] IdleWord = {IDLE_HDR, 26'b0};
   localparam logic [3:0]  GapLast  = 4'(MIN_GAP);

   typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

   state_e        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    gap_q, gap_d;
   logic [103:0]  shift_q, shift_d;
   logic [29:0]   data_q, data_d;
   logic [15:0]   sent_q, sent_d;

   logic          launch;
   logic [103:0]  launch_frame;

`ifdef STRIP_FRAME_GEN_TESTPAT_EN
   logic [23:0]   pat_q;
   logic          launch_pat;
   logic [103:0]  pat_frame;

   assign launch_pat   = (state_q == StIdle) && test_mode;
   assign pat_frame    = {pat_q, 2'd0, pat_q, 2'd1, pat_q, 2'd2, pat_q, 2'd3};
   assign launch       = launch_pat || (src.frame_valid && src.frame_ready);
   assign launch_frame = launch_pat ? pat_frame : src.frame_in;

   always_ff @(posedge clk160) begin
      if (reset) begin
         pat_q <= '0;
      end else if (launch_pat) begin
         pat_q <= pat_q + 24'd1;
      end
   end
`else
   assign launch       = src.frame_valid && src.frame_ready;
   assign launch_frame = src.frame_in;
`endif

   always_ff @(posedge clk160) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         gap_q   <= '0;
         shift_q <= '0;
         data_q  <= IdleWord;
         sent_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         sent_q  <= sent_d;
      end
   end

   // The shift register holds the not-yet-sent slices, next slice always in [103:78].
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      shift_d = shift_q;
      data_d  = data_q;
      sent_d  = sent_q;
      unique case (state_q)
         StIdle: begin
            data_d = IdleWord;
            if (launch) begin
               data_d  = {DataHdr, launch_frame[103:78]};
               shift_d = {launch_frame[77:0], 26'b0};
               idx_d   = 2'd1;
               state_d = StSend;
            end
         end
         StSend: begin
            data_d  = {DataHdr, shift_q[103:78]};
            shift_d = {shift_q[77:0], 26'b0};
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_d = StGap;
               gap_d   = 4'd1;
               sent_d  = sent_q + 16'd1;
            end
         end
         StGap: begin
            data_d = IdleWord;
            if (gap_q == GapLast) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
            data_d  = IdleWord;
         end
      endcase
   end

   always_comb begin
      src.frame_ready = (state_q == StIdle) && !reset;
`ifdef STRIP_FRAME_GEN_TESTPAT_EN
      if (test_mode) begin
         src.frame_ready = 1'b0;
      end
`endif
      busy = (state_q != StIdle);
   end

   assign strip_data_out = data_q;
   assign frames_sent    = sent_q;

endmodule

// File: tb/tb_strip_frame_gen.sv
// Bench for strip_frame_gen: word-schedule reference model plus a loopback frame rebuilder.
// Define STRIP_FRAME_GEN_TESTPAT_EN to also exercise the test pattern source.
module tb_strip_frame_gen;
   localparam int unsigned G      = 3;
   localparam logic [29:0] IDLE_W = 30'h1400_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] data_out;
   logic        busy;
   logic [15:0] sent;
`ifdef STRIP_FRAME_GEN_TESTPAT_EN
   logic        test_mode;
`endif

   strip_frame_gen_if fif ();

   strip_frame_gen #(.MIN_GAP(G), .IDLE_HDR(4'b0101)) dut (
      .clk160         (clk),
      .reset          (rst),
`ifdef STRIP_FRAME_GEN_TESTPAT_EN
      .test_mode      (test_mode),
`endif
      .src            (fif),
      .strip_data_out (data_out),
      .busy           (busy),
      .frames_sent    (sent)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: every launched frame becomes a list of words, one per future edge.
   typedef struct {
      logic [29:0]  word;
      bit           last;
      logic [103:0] frame;
   } slot_t;

   slot_t        sched[$];
   logic [103:0] tx_q[$];
   logic [29:0]  m_out = IDLE_W;
   int           m_sent = 0;
   logic [23:0]  m_pat = '0;
   int           cyc = 0;

   // Loopback receiver state
   logic [3:0]   prev_hdr = 4'b0101;
   logic [103:0] rx_buf = '0;
   int           rx_cnt = 0;
   int           rx_frames = 0;
   int           last_start = -1;
   bit           chk_period = 1'b0;

   function automatic void m_launch(input logic [103:0] f);
      slot_t s;
      for (int k = 0; k < 4; k++) begin
         s.word  = {4'b1010, f[103 - 26*k -: 26]};
         s.last  = (k == 3);
         s.frame = f;
         sched.push_back(s);
      end
      for (int k = 0; k < int'(G); k++) begin
         s.word  = IDLE_W;
         s.last  = 1'b0;
         s.frame = '0;
         sched.push_back(s);
      end
   endfunction

   function automatic logic [103:0] rand_frame();
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      return r[103:0];
   endfunction

   task automatic rx_watch();
      if (data_out[29:26] == 4'b1010) begin
         if (prev_hdr != 4'b1010) begin
            if (chk_period && last_start >= 0) begin
               check_eq("period", 64'(cyc - last_start), 64'(4 + G));
            end
            last_start = cyc;
            rx_cnt     = 0;
         end
         rx_buf = {rx_buf[77:0], data_out[25:0]};
         rx_cnt++;
         if (rx_cnt == 4) begin
            check_eq("rx_pending", 64'(tx_q.size() > 0), 64'd1);
            if (tx_q.size() > 0) begin
               check_eq("rx_frame_lo", rx_buf[63:0], tx_q[0][63:0]);
               check_eq("rx_frame_hi", 64'(rx_buf[103:64]), 64'(tx_q[0][103:64]));
               void'(tx_q.pop_front());
            end
            rx_frames++;
         end
      end
      prev_hdr = data_out[29:26];
   endtask

   // One clock cycle: drive inputs at negedge, check, then advance the model at the edge.
   task automatic step(input bit v, input logic [103:0] f, input bit r, input bit tm);
      slot_t s;
      @(negedge clk);
      rst             = r;
      fif.frame_valid = v;
      fif.frame_in    = f;
`ifdef STRIP_FRAME_GEN_TESTPAT_EN
      test_mode       = tm;
`endif
      #1;
      check_eq("ready", 64'(fif.frame_ready), 64'(sched.size() == 0 && !r && !tm));
      check_eq("data", 64'(data_out), 64'(m_out));
      check_eq("busy", 64'(busy), 64'(sched.size() != 0));
      check_eq("sent", 64'(sent), 64'(m_sent[15:0]));
      rx_watch();
      @(posedge clk);
      cyc++;
      if (r) begin
         sched.delete();
         m_out  = IDLE_W;
         m_sent = 0;
         m_pat  = '0;
      end else begin
         if (sched.size() == 0) begin
            if (tm) begin
               m_launch({m_pat, 2'd0, m_pat, 2'd1, m_pat, 2'd2, m_pat, 2'd3});
               m_pat++;
            end else if (v) begin
               m_launch(f);
            end
         end
         if (sched.size() != 0) begin
            s     = sched.pop_front();
            m_out = s.word;
            if (s.last) begin
               m_sent++;
               tx_q.push_back(s.frame);
            end
         end else begin
            m_out = IDLE_W;
         end
      end
   endtask

   logic [29:0]  t2_exp[4] = '{30'h2B00_0001, 30'h2A00_0002, 30'h2900_0003, 30'h2800_0004};
   logic [103:0] f1 = {26'h300_0001, 26'h200_0002, 26'h100_0003, 26'h000_0004};

   initial begin
      int base;
      int guard;
      rst             = 1'b1;
      fif.frame_valid = 1'b0;
      fif.frame_in    = '0;
`ifdef STRIP_FRAME_GEN_TESTPAT_EN
      test_mode       = 1'b0;
`endif
      repeat (3) step(1'b0, '0, 1'b1, 1'b0);

      // Reset release, no traffic; frame_in must be ignored
      repeat (5) step(1'b0, rand_frame(), 1'b0, 1'b0);
      #1;
      check_eq("t1_idle", 64'(data_out), 64'h1400_0000);
      check_eq("t1_ready", 64'(fif.frame_ready), 64'd1);
      check_eq("t1_sent", 64'(sent), 64'd0);

      // Single known frame
      step(1'b1, f1, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq("t2_word", 64'(data_out), 64'(t2_exp[k]));
         step(1'b0, '0, 1'b0, 1'b0);
      end
      #1;
      check_eq("t2_gap", 64'(data_out), 64'h1400_0000);
      check_eq("t2_sent", 64'(sent), 64'd1);
      repeat (G + 1) step(1'b0, '0, 1'b0, 1'b0);

      // Reset after word 1, then an intact frame
      step(1'b1, rand_frame(), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      #1;
      check_eq("t3_idle", 64'(data_out), 64'h1400_0000);
      check_eq("t3_sent", 64'(sent), 64'd0);
      step(1'b1, rand_frame(), 1'b0, 1'b0);
      repeat (4 + G + 1) step(1'b0, '0, 1'b0, 1'b0);
      #1;
      check_eq("t3_after", 64'(sent), 64'd1);

      // frame_valid held high: back-to-back frames at the minimum period
      base       = m_sent;
      chk_period = 1'b1;
      last_start = -1;
      repeat (10 * (4 + G)) step(1'b1, rand_frame(), 1'b0, 1'b0);
      chk_period = 1'b0;
      #1;
      check_eq("t4_sent", 64'(sent), 64'(base + 10));
      repeat (2) step(1'b0, '0, 1'b0, 1'b0);

      // Random traffic, 1000 frames checked through the loopback receiver
      base      = m_sent;
      rx_frames = 0;
      guard     = 0;
      while (m_sent - base < 1000 && guard < 20000) begin
         step($urandom_range(0, 99) < 70, rand_frame(), 1'b0, 1'b0);
         guard++;
      end
      check_eq("t5_timeout", 64'(guard < 20000), 64'd1);
      repeat (4 + G) step(1'b0, '0, 1'b0, 1'b0);
      check_eq("t5_rx_count", 64'(rx_frames), 64'd1000);
      check_eq("t5_tx_left", 64'(tx_q.size()), 64'd0);

`ifdef STRIP_FRAME_GEN_TESTPAT_EN
      // Test pattern: payloads count up 0..7 over two frames, frame_ready held low
      repeat (2) step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, rand_frame(), 1'b0, 1'b1);
      for (int fr = 0; fr < 2; fr++) begin
         for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("t6_payload", 64'(data_out[25:0]), 64'(4 * fr + k));
            check_eq("t6_ready", 64'(fif.frame_ready), 64'd0);
            step(1'b1, rand_frame(), 1'b0, 1'b1);
         end
         repeat (G) step(1'b1, rand_frame(), 1'b0, 1'b1);
      end
      repeat (4 + G + 1) step(1'b0, '0, 1'b0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
